uart_tx_fifo: RTL and testbench
===============================

# uart_tx_fifo

Configurable UART transmitter with an internal transmit FIFO; next-generation replacement for the fixed-format serialiser. Accepts bytes over a valid/ready stream, buffers up to FIFO_DEPTH words, and serialises them back-to-back with runtime-selectable baud divider, data width, parity and stop-bit count. Sits between the host-side stream fabric and the board TX pin.

## Interface

- MAX_DATA_BITS, 8, width of data_bits; largest selectable frame data width (5..9).
- FIFO_DEPTH, 16, transmit FIFO entries; power of two, >= 2.
- DIVIDER_BITS, 16, width of cfg_divider.
- clock  in  1  system clock.
- reset  in  1  synchronous, active-high.
- cfg_divider  in  DIVIDER_BITS  clocks per bit; 0 treated as 1.
- cfg_data_bits  in  4  data bits per frame; values outside 5..MAX_DATA_BITS mean MAX_DATA_BITS.
- cfg_parity  in  2  00 none, 01 odd, 10 even, 11 none.
- cfg_two_stop  in  1  1 = two stop bits, 0 = one.
- data_valid  in  1  write request.
- data_ready  out  1  FIFO not full.
- data_bits  in  MAX_DATA_BITS  word to send, LSB first; bits at or above cfg_data_bits ignored.
- tx  out  1  serial line, idle high.
- busy  out  1  frame in progress or FIFO non-empty.
- fifo_count  out  $clog2(FIFO_DEPTH+1)  FIFO occupancy.

## Operation

- Reset: FIFO flushed, state IDLE, tx=1, busy=0, fifo_count=0, data_ready=1 from the first cycle after reset. Reset mid-frame aborts immediately; tx high on the next cycle, no partial stop bit.
- FIFO write on data_valid && data_ready. data_ready = (fifo_count != FIFO_DEPTH), combinational from count only; no write-through when full.
- States: IDLE, START, DATA, PARITY, STOP.
  - IDLE: tx=1. If FIFO non-empty: pop head, latch word and all cfg_* inputs into frame registers, go START.
  - START: tx=0 for D clocks -> DATA.
  - DATA: tx = current data bit, LSB first, D clocks each, N bits -> PARITY if parity enabled else STOP.
  - PARITY: tx = parity bit for D clocks; even: XOR of the N data bits; odd: its inverse -> STOP.
  - STOP: tx=1 for D clocks (2D if two-stop). At end: if FIFO non-empty, pop and go START directly (no idle gap); else IDLE.
- D = max(cfg_divider,1), N = effective data bits, both latched at frame start; cfg changes mid-frame affect the next frame only.
- Bit timer: down-counter loaded with D-1 on every bit entry, advances bit/state at 0. Bit counter counts data bits remaining; stop counter counts stop bits.
- Simultaneous push and pop: fifo_count unchanged; push while empty and IDLE is popped no earlier than the following cycle.
- Pointers wrap modulo FIFO_DEPTH; occupancy held in separate counter, full/empty never ambiguous.
- busy = (state != IDLE) || (fifo_count != 0).

## Timing

- tx registered; state, bit timer and tx update on the same edge.
- Push into empty FIFO while IDLE at edge k: fifo_count=1 after k, pop at edge k+1, tx=0 from after k+1 (start bit 2 cycles after handshake).
- Frame length: D*(1 + N + P + S) clocks, P in {0,1}, S in {1,2}.
- Back-to-back frames: next start bit begins the cycle after the last stop-bit clock; zero idle clocks.
- fifo_count reflects push/pop one cycle after the handshake edge.

## Test plan

- Reset then idle: hold reset 3 cycles -> tx=1, busy=0, data_ready=1, fifo_count=0; no tx transition for 100 cycles.
- 8N1, cfg_divider=4, push 0xA5 -> start 2 cycles after push; tx pattern 0,1,0,1,0,0,1,0,1,1 each 4 clocks; frame 40 clocks; busy falls the cycle after final stop clock.
- 7E2, cfg_divider=3, push 0x35 (data 0110101, four ones) -> parity 0; two stop bits; frame 33 clocks; 8O1 with 0x00 -> parity bit 1.
- FIFO full: divider=10, push 20 words without stalling valid -> data_ready low after 16 accepted (fifo_count=16, minus any popped); all accepted words emitted in order, no gaps between frames.
- Config change mid-frame: switch cfg_divider 4->8 during DATA of frame 1 -> frame 1 stays 4 clocks/bit, frame 2 uses 8.
- Reset during DATA bit 3 with 3 words queued -> tx=1 next cycle, fifo_count=0, no further frames.

Source files
------------

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: byte-stream UART transmitter with an internal transmit FIFO.
// Each frame latches its own divider, width, parity and stop configuration,
// so configuration changes only ever affect frames that have not started.
module uart_tx_fifo #(
  parameter int MAX_DATA_BITS = 8,
  parameter int FIFO_DEPTH    = 16,
  parameter int DIVIDER_BITS  = 16
) (
  input  logic                               clock,
  input  logic                               reset,
  input  logic [DIVIDER_BITS-1:0]            cfg_divider_i,
  input  logic [3:0]                         cfg_data_bits_i,
  input  logic [1:0]                         cfg_parity_i,
  input  logic                               cfg_two_stop_i,
  input  logic                               data_valid_i,
  output logic                               data_ready_o,
  input  logic [MAX_DATA_BITS-1:0]           data_bits_i,
  output logic                               tx_o,
  output logic                               busy_o,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]    fifo_count_o
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  logic [MAX_DATA_BITS-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]            wr_ptr_q;
  logic [AW-1:0]            rd_ptr_q;
  logic [CW-1:0]            count_q;

  state_t                   state_q;
  logic                     tx_q;
  logic [DIVIDER_BITS-1:0]  timer_q;
  logic [DIVIDER_BITS-1:0]  div_m1_q;
  logic [MAX_DATA_BITS-1:0] shift_q;
  logic [3:0]               bits_left_q;
  logic                     parity_en_q;
  logic                     parity_bit_q;
  logic                     stop_left_q;

  logic                     push;
  logic                     pop;
  logic                     frame_done;
  logic [3:0]               eff_bits_d;
  logic [MAX_DATA_BITS-1:0] head_masked_d;
  logic [DIVIDER_BITS-1:0]  div_m1_d;
  logic                     parity_en_d;
  logic                     parity_bit_d;

  assign data_ready_o = (count_q != CW'(FIFO_DEPTH));
  assign push         = data_valid_i && data_ready_o;
  assign frame_done   = (state_q == STOP) && (timer_q == '0) && !stop_left_q;
  assign pop          = (count_q != '0) && ((state_q == IDLE) || frame_done);
  assign busy_o       = (state_q != IDLE) || (count_q != '0);
  assign fifo_count_o = count_q;
  assign tx_o         = tx_q;

  // Frame parameters that get latched when the FIFO head is popped.
  always_comb begin
    eff_bits_d = cfg_data_bits_i;
    if (cfg_data_bits_i < 4'd5 || cfg_data_bits_i > 4'(MAX_DATA_BITS)) begin
      eff_bits_d = 4'(MAX_DATA_BITS);
    end
    head_masked_d = '0;
    for (int i = 0; i < MAX_DATA_BITS; i++) begin
      if (4'(i) < eff_bits_d) begin
        head_masked_d[i] = mem_q[rd_ptr_q][i];
      end
    end
    div_m1_d     = (cfg_divider_i == '0) ? '0 : cfg_divider_i - DIVIDER_BITS'(1);
    parity_en_d  = (cfg_parity_i == 2'b01) || (cfg_parity_i == 2'b10);
    parity_bit_d = (cfg_parity_i == 2'b01) ? ~(^head_masked_d) : (^head_masked_d);
  end

  // FIFO storage; masking of unused bits happens at pop time.
  always_ff @(posedge clock) begin
    if (push) begin
      mem_q[wr_ptr_q] <= data_bits_i;
    end
  end

  // FIFO pointers and occupancy; a simultaneous push and pop leaves the count alone.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Frame sequencer: state, bit timer and registered tx all move on the same edge.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= IDLE;
      tx_q         <= 1'b1;
      timer_q      <= '0;
      div_m1_q     <= '0;
      shift_q      <= '0;
      bits_left_q  <= '0;
      parity_en_q  <= 1'b0;
      parity_bit_q <= 1'b0;
      stop_left_q  <= 1'b0;
    end else if (pop) begin
      state_q      <= START;
      tx_q         <= 1'b0;
      timer_q      <= div_m1_d;
      div_m1_q     <= div_m1_d;
      shift_q      <= head_masked_d;
      bits_left_q  <= eff_bits_d;
      parity_en_q  <= parity_en_d;
      parity_bit_q <= parity_bit_d;
      stop_left_q  <= cfg_two_stop_i;
    end else begin
      case (state_q)
        IDLE: begin
          tx_q <= 1'b1;
        end
        START: begin
          if (timer_q == '0) begin
            state_q     <= DATA;
            tx_q        <= shift_q[0];
            shift_q     <= shift_q >> 1;
            bits_left_q <= bits_left_q - 4'd1;
            timer_q     <= div_m1_q;
          end else begin
            timer_q <= timer_q - DIVIDER_BITS'(1);
          end
        end
        DATA: begin
          if (timer_q == '0) begin
            timer_q <= div_m1_q;
            if (bits_left_q != 4'd0) begin
              tx_q        <= shift_q[0];
              shift_q     <= shift_q >> 1;
              bits_left_q <= bits_left_q - 4'd1;
            end else if (parity_en_q) begin
              state_q <= PARITY;
              tx_q    <= parity_bit_q;
            end else begin
              state_q <= STOP;
              tx_q    <= 1'b1;
            end
          end else begin
            timer_q <= timer_q - DIVIDER_BITS'(1);
          end
        end
        PARITY: begin
          if (timer_q == '0) begin
            state_q <= STOP;
            tx_q    <= 1'b1;
            timer_q <= div_m1_q;
          end else begin
            timer_q <= timer_q - DIVIDER_BITS'(1);
          end
        end
        STOP: begin
          if (timer_q == '0) begin
            if (stop_left_q) begin
              stop_left_q <= 1'b0;
              timer_q     <= div_m1_q;
            end else begin
              state_q <= IDLE;
              tx_q    <= 1'b1;
            end
          end else begin
            timer_q <= timer_q - DIVIDER_BITS'(1);
          end
        end
        default: begin
          state_q <= IDLE;
          tx_q    <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: directed stimulus pushes expected frames into a scoreboard;
// a line monitor decodes tx and checks every bit time against the queue head.
module tb_uart_tx_fifo;

  localparam int MAXB  = 8;
  localparam int DEPTH = 16;
  localparam int DIVB  = 16;

  logic            clock = 1'b0;
  logic            reset = 1'b1;
  logic [DIVB-1:0] cfg_divider = 16'd4;
  logic [3:0]      cfg_data_bits = 4'd8;
  logic [1:0]      cfg_parity = 2'b00;
  logic            cfg_two_stop = 1'b0;
  logic            data_valid = 1'b0;
  logic            data_ready;
  logic [MAXB-1:0] data_bits = '0;
  logic            tx;
  logic            busy;
  logic [4:0]      fifo_count;

  uart_tx_fifo #(
    .MAX_DATA_BITS(MAXB),
    .FIFO_DEPTH   (DEPTH),
    .DIVIDER_BITS (DIVB)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .cfg_divider_i  (cfg_divider),
    .cfg_data_bits_i(cfg_data_bits),
    .cfg_parity_i   (cfg_parity),
    .cfg_two_stop_i (cfg_two_stop),
    .data_valid_i   (data_valid),
    .data_ready_o   (data_ready),
    .data_bits_i    (data_bits),
    .tx_o           (tx),
    .busy_o         (busy),
    .fifo_count_o   (fifo_count)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [7:0] data;
    int         n;
    bit         parEn;
    bit         parBit;
    int         stops;
    int         d;
    int         rule;
    int         startAt;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   failed = 0;
  int   cyc = 0;

  // Edge counter; read half a cycle or #1 after an edge it equals that edge's index.
  always @(posedge clock) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input int actual, input int expected);
    tests++;
    if (actual != expected) begin
      failed++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  bit   monActive = 0;
  bit   monSkip = 0;
  exp_t cur;
  int   bitsExp [16];
  int   nBits = 0;
  int   bitIdx = 0;
  int   cycInBit = 0;
  int   heldOk = 0;
  int   frameNo = 0;
  int   lastEnd = -100;

  // Line monitor: detects start bits, pops the expected frame and checks each bit time.
  always @(negedge clock) begin
    if (reset) begin
      monActive = 0;
      monSkip   = 0;
    end else if (monSkip) begin
      if (tx) monSkip = 0;
    end else if (!monActive && tx == 1'b0) begin
      if (sb.size() == 0) begin
        checkOutput("unexpectedStart", 1, 0);
        monSkip = 1;
      end else begin
        cur = sb.pop_front();
        frameNo++;
        nBits = 0;
        bitsExp[nBits] = 0;
        nBits = nBits + 1;
        for (int i = 0; i < cur.n; i++) begin
          bitsExp[nBits] = int'(cur.data[i]);
          nBits = nBits + 1;
        end
        if (cur.parEn) begin
          bitsExp[nBits] = int'(cur.parBit);
          nBits = nBits + 1;
        end
        for (int i = 0; i < cur.stops; i++) begin
          bitsExp[nBits] = 1;
          nBits = nBits + 1;
        end
        if (cur.rule == 1)
          checkOutput($sformatf("frame%0d startCycle", frameNo), cyc, cur.startAt);
        else if (cur.rule == 2)
          checkOutput($sformatf("frame%0d backToBackStart", frameNo), cyc, lastEnd + 1);
        monActive = 1;
        bitIdx    = 0;
        cycInBit  = 0;
        heldOk    = 0;
      end
    end
    if (monActive) begin
      if (int'(tx) == bitsExp[bitIdx]) heldOk++;
      cycInBit++;
      if (cycInBit == cur.d) begin
        checkOutput($sformatf("frame%0d bit%0d clocksCorrect", frameNo, bitIdx), heldOk, cur.d);
        bitIdx++;
        cycInBit = 0;
        heldOk   = 0;
        if (bitIdx == nBits) begin
          monActive = 0;
          lastEnd   = cyc;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic waitUntil(input int c);
    int guard = 0;
    while (cyc < c && guard < 5000) begin
      tick();
      guard++;
    end
  endtask

  task automatic applyStimulus(input logic [7:0] word, input int n, input bit parEn,
                               input bit parBit, input int stops, input int d,
                               input int rule, output int k);
    exp_t e;
    int   guard = 0;
    data_bits  = word;
    data_valid = 1'b1;
    while (!data_ready && guard < 1000) begin
      tick();
      guard++;
    end
    if (!data_ready) begin
      checkOutput("pushTimeout", 0, 1);
      data_valid = 1'b0;
      k = cyc;
      return;
    end
    tick();
    k = cyc;
    data_valid = 1'b0;
    e.data = word; e.n = n; e.parEn = parEn; e.parBit = parBit;
    e.stops = stops; e.d = d; e.rule = rule; e.startAt = k + 1;
    sb.push_back(e);
  endtask

  task automatic waitDrain(input int budget);
    int g = 0;
    while ((sb.size() != 0 || monActive) && g < budget) begin
      tick();
      g++;
    end
    checkOutput("drainCompleted", (sb.size() == 0 && !monActive) ? 1 : 0, 1);
  endtask

  // Hard stop in case something blocks forever.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed test sequence.
  initial begin
    int k, k2, lows, accepted;
    bit sawFull;

    // reset held three cycles, then a quiet idle line
    repeat (3) tick();
    checkOutput("resetTx", tx, 1);
    checkOutput("resetBusy", busy, 0);
    checkOutput("resetReady", data_ready, 1);
    checkOutput("resetCount", fifo_count, 0);
    reset = 1'b0;
    lows = 0;
    repeat (100) begin
      tick();
      if (tx !== 1'b1) lows++;
    end
    checkOutput("idleLowClocks", lows, 0);

    // 8N1, divider 4, 0xA5
    cfg_divider = 16'd4; cfg_data_bits = 4'd8; cfg_parity = 2'b00; cfg_two_stop = 1'b0;
    applyStimulus(8'hA5, 8, 0, 0, 1, 4, 1, k);
    checkOutput("countAfterPush", fifo_count, 1);
    checkOutput("busyAfterPush", busy, 1);
    tick();
    checkOutput("countAfterPop", fifo_count, 0);
    waitUntil(k + 40);
    checkOutput("8N1 busyLastStop", busy, 1);
    tick();
    checkOutput("8N1 busyAfterFrame", busy, 0);
    checkOutput("8N1 txIdle", tx, 1);

    // 7E2, divider 3, bit 7 set but ignored; parity over four ones is 0
    cfg_divider = 16'd3; cfg_data_bits = 4'd7; cfg_parity = 2'b10; cfg_two_stop = 1'b1;
    applyStimulus(8'hB5, 7, 1, 0, 2, 3, 1, k);
    waitUntil(k + 33);
    checkOutput("7E2 busyLastStop", busy, 1);
    tick();
    checkOutput("7E2 busyAfterFrame", busy, 0);

    // 8O1, divider 3, 0x00 gives odd parity bit 1
    cfg_data_bits = 4'd8; cfg_parity = 2'b01; cfg_two_stop = 1'b0;
    applyStimulus(8'h00, 8, 1, 1, 1, 3, 1, k);
    waitUntil(k + 33);
    checkOutput("8O1 busyLastStop", busy, 1);
    tick();
    checkOutput("8O1 busyAfterFrame", busy, 0);

    // FIFO fill: 20 words with valid held, divider 10, 8N1
    cfg_divider = 16'd10; cfg_parity = 2'b00;
    sawFull = 0;
    accepted = 0;
    for (int i = 0; i < 20; i++) begin
      if (!data_ready && !sawFull) begin
        sawFull = 1;
        checkOutput("acceptedBeforeFull", accepted, 17);
        checkOutput("countAtFull", fifo_count, 16);
      end
      applyStimulus(8'(i * 37 + 5), 8, 0, 0, 1, 10, (i == 0) ? 1 : 2, k);
      accepted++;
    end
    checkOutput("fullObserved", sawFull ? 1 : 0, 1);
    waitDrain(2500);
    tick();
    checkOutput("fullBusyEnd", busy, 0);

    // divider changed 4 -> 8 during frame 1 data; frame 2 uses 8
    cfg_divider = 16'd4;
    applyStimulus(8'h3C, 8, 0, 0, 1, 4, 1, k);
    applyStimulus(8'hC3, 8, 0, 0, 1, 8, 2, k2);
    checkOutput("pushPopSameEdgeCount", fifo_count, 1);
    waitUntil(k + 8);
    cfg_divider = 16'd8;
    waitDrain(300);
    tick();
    checkOutput("cfgChangeBusyEnd", busy, 0);

    // reset during data bit 3 of frame 1 with three words queued
    cfg_divider = 16'd4;
    applyStimulus(8'h00, 8, 0, 0, 1, 4, 1, k);
    applyStimulus(8'hFF, 8, 0, 0, 1, 4, 2, k2);
    applyStimulus(8'h0F, 8, 0, 0, 1, 4, 2, k2);
    applyStimulus(8'hF0, 8, 0, 0, 1, 4, 2, k2);
    checkOutput("queuedBeforeReset", fifo_count, 3);
    waitUntil(k + 18);
    checkOutput("midFrameTxLow", tx, 0);
    reset = 1'b1;
    sb.delete();
    tick();
    checkOutput("abortTx", tx, 1);
    checkOutput("abortCount", fifo_count, 0);
    checkOutput("abortBusy", busy, 0);
    checkOutput("abortReady", data_ready, 1);
    tick();
    reset = 1'b0;
    lows = 0;
    repeat (150) begin
      tick();
      if (tx !== 1'b1) lows++;
    end
    checkOutput("postAbortLowClocks", lows, 0);
    checkOutput("postAbortBusy", busy, 0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
